// File: rtl/cnt_drv_pkg.sv
// cnt_drv_pkg: shared state encoding and LOAD select codes for the
// loadable up-counter initiator (cnt_load_driver).
package cnt_drv_pkg;

    // FSM encoding kept as fixed 3-bit codes so legacy dumps stay readable
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LD   = 3'd1,
        RUN  = 3'd2,
        FIN  = 3'd3,
        FAIL = 3'd4
    } state_t;

    // Default LOAD select values understood by the counter block
    localparam logic [2:0] LOAD_IDLE = 3'd0;
    localparam logic [2:0] LOAD_CODE = 3'd1;

endpackage

// File: rtl/cnt_expect.sv
// cnt_expect: expected-count tracker for cnt_load_driver.
// Holds the expected counter value, its load/increment (wrapping mod
// 2^WIDTH), the terminal-count compare and, when CNT_CHECK_EN is defined,
// the compare of the fed-back CNT against the expected value.
module cnt_expect #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] stop_val,
    input  logic [WIDTH-1:0] cnt,
    output logic             at_stop,
    output logic             mismatch
);

    logic [WIDTH-1:0] exp_r;

    // Expected count: reload with the start value, then step with the counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            exp_r <= start_val;
        end else if (inc) begin
            exp_r <= exp_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            exp_r <= exp_r;
        end
    end

    assign at_stop = (exp_r == stop_val);

`ifdef CNT_CHECK_EN
    assign mismatch = (cnt != exp_r);
`else
    // Without the checker the fed-back count is deliberately ignored
    logic unused_cnt_s;
    assign unused_cnt_s = ^cnt;
    assign mismatch     = 1'b0;
`endif

endmodule

// File: rtl/cnt_load_driver.sv
// cnt_load_driver: initiator for the loadable up-counter (CNT/ENA/LOAD/DATA).
// Accepts a {start, stop} request, loads the counter with start for one
// cycle, then enables it until the expected count reaches stop.
// Optional macro CNT_CHECK_EN: when defined, CNT is compared against the
// expected count every RUN cycle; a mismatch aborts to FAIL and sets the
// sticky ERR flag. When undefined, ERR is tied low and FAIL is unreachable.
module cnt_load_driver #(
    parameter int         WIDTH     = 8,
    parameter logic [2:0] LOAD_CODE = cnt_drv_pkg::LOAD_CODE,
    parameter logic [2:0] LOAD_IDLE = cnt_drv_pkg::LOAD_IDLE
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             START,
    input  logic             ABORT,
    input  logic [WIDTH-1:0] START_VAL,
    input  logic [WIDTH-1:0] STOP_VAL,
    input  logic [WIDTH-1:0] CNT,
    output logic             ENA,
    output logic [2:0]       LOAD,
    output logic [WIDTH-1:0] DATA,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    import cnt_drv_pkg::*;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] start_r;
    logic [WIDTH-1:0] stop_r;
    logic [WIDTH-1:0] data_r;
    logic [2:0]       load_r;
    logic             busy_r;
    logic             done_r;
    logic             accept_s;
    logic             exp_clr_s;
    logic             exp_inc_s;
    logic             at_stop_s;
    logic             mismatch_s;
    logic             ena_s;

    cnt_expect #(
        .WIDTH (WIDTH)
    ) u_expect (
        .clk       (CLOCK),
        .rst       (RESET),
        .clr       (exp_clr_s),
        .inc       (exp_inc_s),
        .start_val (start_r),
        .stop_val  (stop_r),
        .cnt       (CNT),
        .at_stop   (at_stop_s),
        .mismatch  (mismatch_s)
    );

    // Next-state logic; ABORT overrides every transition out of a busy state
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        exp_clr_s   = 1'b0;
        exp_inc_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (START && !ABORT) begin
                    state_nxt_s = LD;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LD: begin
                if (ABORT) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RUN;
                    exp_clr_s   = 1'b1;
                end
            end
            RUN: begin
                if (ABORT) begin
                    state_nxt_s = IDLE;
                end else if (mismatch_s) begin
                    state_nxt_s = FAIL;
                end else if (at_stop_s) begin
                    state_nxt_s = FIN;
                end else begin
                    state_nxt_s = RUN;
                    exp_inc_s   = 1'b1;
                end
            end
            FIN: begin
                state_nxt_s = IDLE;
            end
            FAIL: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Counter enable follows the RUN state and exp in the same cycle so the
    // counter steps in lockstep with exp; dropped on mismatch or abort
    always_comb begin
        if (state_r == RUN) begin
            ena_s = !at_stop_s && !mismatch_s && !ABORT;
        end else begin
            ena_s = 1'b0;
        end
    end

    // State register and request capture
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_r <= IDLE;
            start_r <= {WIDTH{1'b0}};
            stop_r  <= {WIDTH{1'b0}};
            data_r  <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                start_r <= START_VAL;
                stop_r  <= STOP_VAL;
                data_r  <= START_VAL;
            end else begin
                start_r <= start_r;
                stop_r  <= stop_r;
                data_r  <= data_r;
            end
        end
    end

    // Registered LOAD/BUSY/DONE decoded from the state being entered
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            load_r <= LOAD_IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            load_r <= (state_nxt_s == LD) ? LOAD_CODE : LOAD_IDLE;
            busy_r <= (state_nxt_s != IDLE);
            done_r <= (state_nxt_s == FIN);
        end
    end

`ifdef CNT_CHECK_EN
    logic err_r;

    // Sticky error: cleared by an accepted request, set on entering FAIL
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            err_r <= 1'b0;
        end else if (accept_s) begin
            err_r <= 1'b0;
        end else if (state_nxt_s == FAIL) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign ERR = err_r;
`else
    assign ERR = 1'b0;
`endif

    assign ENA  = ena_s;
    assign LOAD = load_r;
    assign DATA = data_r;
    assign BUSY = busy_r;
    assign DONE = done_r;

endmodule

// File: tb/tb_cnt_load_driver.sv
// tb_cnt_load_driver: scoreboard bench for cnt_load_driver with a
// behavioural loadable up-counter closing the CNT loop. The driver pushes
// the hand-computed outcome of each request; the monitor measures each
// operation from accept to BUSY falling and compares against the queue.
module tb_cnt_load_driver;

    localparam int         WIDTH = 8;
    localparam logic [2:0] LCODE = 3'd1;
    localparam logic [2:0] LIDLE = 3'd0;

    logic             CLOCK = 1'b0;
    logic             RESET;
    logic             START;
    logic             ABORT;
    logic [WIDTH-1:0] START_VAL;
    logic [WIDTH-1:0] STOP_VAL;
    logic [WIDTH-1:0] CNT;
    logic             ENA;
    logic [2:0]       LOAD;
    logic [WIDTH-1:0] DATA;
    logic             BUSY;
    logic             DONE;
    logic             ERR;

    int   vectors     = 0;
    int   miscompares = 0;
    logic skip_en     = 1'b0;

    typedef struct {
        logic       done;
        int         lat;
        int         ena;
        int         loads;
        logic       err;
        logic [7:0] cnt;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];

    always #5 CLOCK = ~CLOCK;

    cnt_load_driver #(
        .WIDTH     (WIDTH),
        .LOAD_CODE (LCODE),
        .LOAD_IDLE (LIDLE)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .START     (START),
        .ABORT     (ABORT),
        .START_VAL (START_VAL),
        .STOP_VAL  (STOP_VAL),
        .CNT       (CNT),
        .ENA       (ENA),
        .LOAD      (LOAD),
        .DATA      (DATA),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR)
    );

    // Behavioural counter; skip_en makes it jump 3 -> 5 to provoke a mismatch
    always @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            CNT <= 8'd0;
        end else if (LOAD == LCODE) begin
            CNT <= DATA;
        end else if (ENA) begin
            CNT <= (skip_en && CNT == 8'd3) ? CNT + 8'd2 : CNT + 8'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic d, input int lat, input int ena,
                                input logic err, input logic [7:0] cnt, input logic [7:0] data);
        exp_t e;
        e.done  = d;
        e.lat   = lat;
        e.ena   = ena;
        e.loads = 1;
        e.err   = err;
        e.cnt   = cnt;
        e.data  = data;
        return e;
    endfunction

    // Monitor: cycle indices are negedge samples; latency runs from the
    // sample where START is accepted to the sample where DONE is high
    initial begin : monitor
        int   cyc;
        int   acc_cyc;
        int   done_cyc;
        int   ena_n;
        int   load_n;
        int   done_n;
        logic tracking;
        logic busy_q;
        exp_t e;
        cyc      = 0;
        acc_cyc  = 0;
        done_cyc = 0;
        ena_n    = 0;
        load_n   = 0;
        done_n   = 0;
        tracking = 1'b0;
        busy_q   = 1'b0;
        forever begin
            @(negedge CLOCK);
            cyc++;
            if (RESET) begin
                tracking = 1'b0;
                busy_q   = 1'b0;
            end else begin
                if (!BUSY && START && !ABORT) begin
                    tracking = 1'b1;
                    acc_cyc  = cyc;
                    ena_n    = 0;
                    load_n   = 0;
                    done_n   = 0;
                    done_cyc = 0;
                end else if (tracking) begin
                    if (ENA) ena_n++;
                    if (LOAD == LCODE) load_n++;
                    if (DONE) begin
                        done_n++;
                        done_cyc = cyc;
                    end
                    if (busy_q && !BUSY) begin
                        tracking = 1'b0;
                        if (sb_q.size() == 0) begin
                            check("unexpected_completion", 32'd1, 32'd0);
                        end else begin
                            e = sb_q.pop_front();
                            check("done_pulses", done_n, e.done ? 1 : 0);
                            if (e.done) check("done_latency", done_cyc - acc_cyc, e.lat);
                            check("ena_cycles", ena_n, e.ena);
                            check("load_cycles", load_n, e.loads);
                            check("err", ERR, e.err);
                            check("final_cnt", CNT, e.cnt);
                            check("data_hold", DATA, e.data);
                        end
                    end
                end
                busy_q = BUSY;
            end
        end
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    // One request: START for one cycle, then RUN with optional re-pulse/abort
    task automatic run_txn(input logic [7:0] sv, input logic [7:0] stv, input logic skip,
                           input int abort_at, input logic repulse, input exp_t e);
        int n;
        sb_q.push_back(e);
        skip_en   = skip;
        START_VAL = sv;
        STOP_VAL  = stv;
        START     = 1'b1;
        tick();
        START     = 1'b0;
        START_VAL = ~sv;
        STOP_VAL  = ~stv;
        tick();
        n = 0;
        while (BUSY && n < 600) begin
            START = repulse && (n == 1);
            ABORT = (abort_at == n + 1);
            tick();
            START = 1'b0;
            ABORT = 1'b0;
            n++;
        end
        if (BUSY) check("busy_timeout", 32'd1, 32'd0);
        tick();
        tick();
        skip_en = 1'b0;
    endtask

    initial begin : driver
        RESET     = 1'b1;
        START     = 1'b0;
        ABORT     = 1'b0;
        START_VAL = 8'd0;
        STOP_VAL  = 8'd0;
        #1;
        check("rst_ena",  ENA,  1'b0);
        check("rst_load", LOAD, LIDLE);
        check("rst_data", DATA, 8'd0);
        check("rst_busy", BUSY, 1'b0);
        check("rst_done", DONE, 1'b0);
        check("rst_err",  ERR,  1'b0);
        tick();
        tick();
        RESET = 1'b0;
        tick();

        // Asynchronous reset in the middle of RUN (start=0, stop=8)
        START_VAL = 8'd0;
        STOP_VAL  = 8'd8;
        START     = 1'b1;
        tick();
        START = 1'b0;
        tick();
        tick();
        tick();
        check("pre_rst_busy", BUSY, 1'b1);
        check("pre_rst_ena",  ENA,  1'b1);
        #2;
        RESET = 1'b1;
        #1;
        check("async_rst_ena",  ENA,  1'b0);
        check("async_rst_busy", BUSY, 1'b0);
        check("async_rst_done", DONE, 1'b0);
        check("async_rst_err",  ERR,  1'b0);
        check("async_rst_load", LOAD, LIDLE);
        check("async_rst_data", DATA, 8'd0);
        tick();
        RESET = 1'b0;
        tick();

        // Nominal 0 -> 8: 8 increments, DONE 11 cycles after accept
        run_txn(8'h00, 8'h08, 1'b0, 0, 1'b0, mk(1'b1, 11, 8, 1'b0, 8'h08, 8'h00));
        // start == stop: no increments, DONE 3 cycles after accept
        run_txn(8'h55, 8'h55, 1'b0, 0, 1'b0, mk(1'b1, 3, 0, 1'b0, 8'h55, 8'h55));
        // Wrap FE -> 01: 3 increments through FF, 00
        run_txn(8'hFE, 8'h01, 1'b0, 0, 1'b0, mk(1'b1, 6, 3, 1'b0, 8'h01, 8'hFE));

        // Counter skips 3 -> 5
`ifdef CNT_CHECK_EN
        run_txn(8'h00, 8'h08, 1'b1, 0, 1'b0, mk(1'b0, 0, 4, 1'b1, 8'h05, 8'h00));
        tick();
        check("err_sticky", ERR, 1'b1);
`else
        run_txn(8'h00, 8'h08, 1'b1, 0, 1'b0, mk(1'b1, 11, 8, 1'b0, 8'h09, 8'h00));
        tick();
        check("err_tied_low", ERR, 1'b0);
`endif

        // START re-pulsed during RUN is ignored; accept also clears ERR
        run_txn(8'h0A, 8'h0E, 1'b0, 0, 1'b1, mk(1'b1, 7, 4, 1'b0, 8'h0E, 8'h0A));
        // ABORT in the 4th RUN cycle: 3 increments, no DONE
        run_txn(8'h00, 8'h08, 1'b0, 4, 1'b0, mk(1'b0, 0, 3, 1'b0, 8'h03, 8'h00));

        // ABORT together with START in IDLE: request refused
        START_VAL = 8'h77;
        START     = 1'b1;
        ABORT     = 1'b1;
        tick();
        START = 1'b0;
        ABORT = 1'b0;
        check("abort_start_busy", BUSY, 1'b0);
        check("abort_start_load", LOAD, LIDLE);
        tick();

        // Fresh request after the abort completes normally
        run_txn(8'h20, 8'h25, 1'b0, 0, 1'b0, mk(1'b1, 8, 5, 1'b0, 8'h25, 8'h20));

        repeat (4) tick();
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
